hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline.
- Keeps a shadow copy of the destination-register info for the EX, MEM and WB stages and drives the EX-stage forwarding selects (W_forwardA / W_forwardB).
- Detects load-use hazards and stalls IF/ID while inserting bubbles into ID/EX.
- Flushes wrong-path instructions on a taken branch and freezes the whole pipeline while data memory is busy.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_fwd_sel.sv | 33 +++
 rtl/hazard_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Forwarding select encodings driven on W_forwardA / W_forwardB.
//   - FSM state encoding for hazard_ctrl.
//   - Default register-index width and a saturating increment helper.
package hazard_ctrl_pkg;

  localparam int unsigned RegAwDefault = 5;

  // EX source select encodings; 2'b11 is never driven.
  localparam logic [1:0] HzdSelRs  = 2'b00;
  localparam logic [1:0] HzdSelAlu = 2'b01;
  localparam logic [1:0] HzdSelWb  = 2'b10;

  typedef enum logic [1:0] {
    HzdRun      = 2'b00,
    HzdLuStall  = 2'b01,
    HzdMemHold  = 2'b10
  } hzd_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX source operand.
// Compares the EX source index against the MEM and WB shadow slots; MEM wins over WB and
// writes to register 0 are never forwarded.
// Ports:
//   i_src     - register index read by the instruction in EX
//   i_mem_rd  - destination index held in the MEM slot
//   i_mem_wen - MEM slot writes the register file
//   i_wb_rd   - destination index held in the WB slot
//   i_wb_wen  - WB slot writes the register file
//   o_sel     - HzdSelRs / HzdSelAlu / HzdSelWb
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = RegAwDefault
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_wen,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_wen,
  output logic [1:0]        o_sel
);

  always_comb begin
    o_sel = HzdSelRs;
    if (i_mem_wen && (i_mem_rd != '0) && (i_mem_rd == i_src)) begin
      o_sel = HzdSelAlu;
    end else if (i_wb_wen && (i_wb_rd != '0) && (i_wb_rd == i_src)) begin
      o_sel = HzdSelWb;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline.
// Keeps shadow destination info for EX/MEM/WB, drives EX forwarding selects, stalls on
// load-use hazards, flushes on taken branches and freezes the pipe while data memory waits.
// Optional build macro HZD_STATS_EN adds three saturating 32-bit event counters.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   dec_*                     - fields of the instruction currently in ID
//   br_taken                  - branch in EX resolved taken
//   mem_wait                  - data memory not ready
//   W_forwardA / W_forwardB   - EX source selects
//   pc_stall, if_id_stall     - hold PC and IF/ID
//   if_id_flush, id_ex_flush  - zero IF/ID, bubble into ID/EX
//   pipe_freeze               - hold ID/EX, EX/MEM, MEM/WB
//   stat_* (HZD_STATS_EN)     - load-use stall cycles, branch flushes, freeze cycles
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned REG_AW   = RegAwDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic              dec_uses_rt,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_w_reg_en,
  input  logic              dec_wb_sel,
  input  logic              br_taken,
  input  logic              mem_wait,
  output logic [1:0]        W_forwardA,
  output logic [1:0]        W_forwardB,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pipe_freeze
`ifdef HZD_STATS_EN
  ,
  output logic [31:0]       stat_lu_cycles,
  output logic [31:0]       stat_flushes,
  output logic [31:0]       stat_freeze_cycles
`endif
);

  // Cycles spent in LU_STALL after the detecting cycle, minus one (counts down to 0).
  localparam bit         MultiCycle = (LOAD_LAT > 1);
  localparam logic [1:0] CntInit    = MultiCycle ? 2'(LOAD_LAT - 2) : 2'd0;

  hzd_state_e r_state, w_state_d;
  logic [1:0] r_cnt, w_cnt_d;

  // Shadow slots. The MEM slot drops the load flag: nothing consumes it past EX.
  logic [REG_AW-1:0] r_ex_rs, r_ex_rt, r_ex_rd;
  logic              r_ex_wen, r_ex_load;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_wen;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_wen;

  logic w_lu;
  logic w_ex_take;

  assign w_lu = r_ex_load && r_ex_wen && (r_ex_rd != '0) && dec_valid &&
                ((r_ex_rd == dec_rs) || (dec_uses_rt && (r_ex_rd == dec_rt)));

  // ---------------------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------------------
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    unique case (r_state)
      HzdLuStall: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        if (mem_wait) begin
          pipe_freeze = 1'b1;
        end else if (r_cnt == 2'd0) begin
          w_state_d = HzdRun;
        end else begin
          w_cnt_d = r_cnt - 2'd1;
        end
      end
      // MEM_HOLD behaves as RUN on its release cycle so a hazard pending behind the freeze
      // is still caught (slots and IF/ID were held, so lu is re-evaluated unchanged).
      HzdRun, HzdMemHold: begin
        if (mem_wait) begin
          pipe_freeze = 1'b1;
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          w_state_d   = HzdMemHold;
        end else if (br_taken) begin
          // The dependent instruction is wrong-path, so the flush beats the load-use stall.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_state_d   = HzdRun;
        end else if (w_lu) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          w_state_d   = MultiCycle ? HzdLuStall : HzdRun;
          w_cnt_d     = CntInit;
        end else begin
          w_state_d = HzdRun;
        end
      end
      default: begin
        w_state_d = HzdRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HzdRun;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Shadow slots
  // ---------------------------------------------------------------------------------------
  assign w_ex_take = dec_valid && !id_ex_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_rs   <= '0;
      r_ex_rt   <= '0;
      r_ex_rd   <= '0;
      r_ex_wen  <= 1'b0;
      r_ex_load <= 1'b0;
      r_mem_rd  <= '0;
      r_mem_wen <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_wen  <= 1'b0;
    end else if (!pipe_freeze) begin
      // Bubbles are fully zeroed so they never match a forwarding compare.
      r_ex_rs   <= w_ex_take ? dec_rs : '0;
      r_ex_rt   <= w_ex_take ? dec_rt : '0;
      r_ex_rd   <= w_ex_take ? dec_rd : '0;
      r_ex_wen  <= w_ex_take && dec_w_reg_en;
      r_ex_load <= w_ex_take && dec_wb_sel;
      r_mem_rd  <= r_ex_rd;
      r_mem_wen <= r_ex_wen;
      r_wb_rd   <= r_mem_rd;
      r_wb_wen  <= r_mem_wen;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Forwarding selects (registered slots only)
  // ---------------------------------------------------------------------------------------
  hazard_ctrl_fwd_sel #(
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .i_src     (r_ex_rs),
    .i_mem_rd  (r_mem_rd),
    .i_mem_wen (r_mem_wen),
    .i_wb_rd   (r_wb_rd),
    .i_wb_wen  (r_wb_wen),
    .o_sel     (W_forwardA)
  );

  hazard_ctrl_fwd_sel #(
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .i_src     (r_ex_rt),
    .i_mem_rd  (r_mem_rd),
    .i_mem_wen (r_mem_wen),
    .i_wb_rd   (r_wb_rd),
    .i_wb_wen  (r_wb_wen),
    .o_sel     (W_forwardB)
  );

`ifdef HZD_STATS_EN
  // ---------------------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------------------
  logic r_unused_ok;
  logic w_lu_cycle;

  // Load-use stall cycle: any LU_STALL cycle, or a RUN cycle stalling without a freeze.
  assign w_lu_cycle = (r_state == HzdLuStall) || (pc_stall && !pipe_freeze);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lu_cycles     <= 32'd0;
      stat_flushes       <= 32'd0;
      stat_freeze_cycles <= 32'd0;
      r_unused_ok        <= 1'b0;
    end else begin
      if (w_lu_cycle)  stat_lu_cycles     <= sat_inc32(stat_lu_cycles);
      if (if_id_flush) stat_flushes       <= sat_inc32(stat_flushes);
      if (pipe_freeze) stat_freeze_cycles <= sat_inc32(stat_freeze_cycles);
      r_unused_ok <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Two instances (LOAD_LAT=1 and LOAD_LAT=3) share the
// same stimulus; a pipeline reference model per instance predicts each cycle's outputs.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       wen;
    logic       load;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       dec_valid = 1'b0, dec_uses_rt = 1'b0, dec_w_reg_en = 1'b0, dec_wb_sel = 1'b0;
  logic       br_taken = 1'b0, mem_wait = 1'b0;
  logic [4:0] dec_rs = '0, dec_rt = '0, dec_rd = '0;

  logic [1:0] fa1, fb1, fa3, fb3;
  logic       pcs1, ifs1, iff1, idf1, frz1;
  logic       pcs3, ifs3, iff3, idf3, frz3;
  logic [8:0] got1, got3;
  assign got1 = {fa1, fb1, pcs1, ifs1, iff1, idf1, frz1};
  assign got3 = {fa3, fb3, pcs3, ifs3, iff3, idf3, frz3};

`ifdef HZD_STATS_EN
  logic [31:0] slu1, sfl1, sfz1, slu3, sfl3, sfz3;
`endif

  hazard_ctrl #(.LOAD_LAT(1), .REG_AW(5)) dut1 (
    .clk (clk), .rst (rst), .dec_valid (dec_valid), .dec_rs (dec_rs), .dec_rt (dec_rt),
    .dec_uses_rt (dec_uses_rt), .dec_rd (dec_rd), .dec_w_reg_en (dec_w_reg_en),
    .dec_wb_sel (dec_wb_sel), .br_taken (br_taken), .mem_wait (mem_wait),
    .W_forwardA (fa1), .W_forwardB (fb1), .pc_stall (pcs1), .if_id_stall (ifs1),
    .if_id_flush (iff1), .id_ex_flush (idf1), .pipe_freeze (frz1)
`ifdef HZD_STATS_EN
    , .stat_lu_cycles (slu1), .stat_flushes (sfl1), .stat_freeze_cycles (sfz1)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3), .REG_AW(5)) dut3 (
    .clk (clk), .rst (rst), .dec_valid (dec_valid), .dec_rs (dec_rs), .dec_rt (dec_rt),
    .dec_uses_rt (dec_uses_rt), .dec_rd (dec_rd), .dec_w_reg_en (dec_w_reg_en),
    .dec_wb_sel (dec_wb_sel), .br_taken (br_taken), .mem_wait (mem_wait),
    .W_forwardA (fa3), .W_forwardB (fb3), .pc_stall (pcs3), .if_id_stall (ifs3),
    .if_id_flush (iff3), .id_ex_flush (idf3), .pipe_freeze (frz3)
`ifdef HZD_STATS_EN
    , .stat_lu_cycles (slu3), .stat_flushes (sfl3), .stat_freeze_cycles (sfz3)
`endif
  );

  // ---------------------------------------------------------------------------------------
  // Reference model: instructions in EX/MEM/WB plus a count of owed load-use stall cycles.
  // ---------------------------------------------------------------------------------------
  slot_t m_ex [2];
  slot_t m_mem[2];
  slot_t m_wb [2];
  int    m_owe[2];
  bit    m_known = 1'b0;

  // bit 9 = compare this entry; [8:0] = {fa, fb, pc, ifs, iff, idf, frz}
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  int vectors = 0;
  int miscompares = 0;
  bit running = 1'b0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Operand source: newest older producer of a non-zero register wins.
  function automatic logic [1:0] fwd(input logic [4:0] src, input slot_t m, input slot_t w);
    if (m.wen && m.rd != 5'd0 && m.rd == src) return 2'b01;
    if (w.wen && w.rd != 5'd0 && w.rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic cyc(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input bit urt, input bit wen, input bit ld,
                     input bit br, input bit mw, input bit r);
    slot_t      ns;
    logic [8:0] e;
    bit         lu, adv, bub;
    rst = r; dec_valid = v; dec_rs = rs; dec_rt = rt; dec_rd = rd; dec_uses_rt = urt;
    dec_w_reg_en = wen; dec_wb_sel = ld; br_taken = br; mem_wait = mw;
    for (int d = 0; d < 2; d++) begin
      lu  = m_ex[d].load && m_ex[d].wen && m_ex[d].rd != 5'd0 && v &&
            (m_ex[d].rd == rs || (urt && m_ex[d].rd == rt));
      ns  = v ? {rs, rt, rd, wen, ld} : '0;
      e   = {fwd(m_ex[d].rs, m_mem[d], m_wb[d]), fwd(m_ex[d].rt, m_mem[d], m_wb[d]), 5'b0};
      adv = 1'b0;
      bub = 1'b0;
      if (m_owe[d] > 0) begin
        e[4:0] = {4'b1101, mw};
        if (!mw) begin adv = 1'b1; bub = 1'b1; m_owe[d]--; end
      end else if (mw) begin
        e[4:0] = 5'b11001;
      end else if (br) begin
        e[4:0] = 5'b00110; adv = 1'b1; bub = 1'b1;
      end else if (lu) begin
        e[4:0] = 5'b11010; adv = 1'b1; bub = 1'b1; m_owe[d] = lat_of(d) - 1;
      end else begin
        adv = 1'b1;
      end
      if (d == 0) q0.push_back({!r && m_known, e});
      else        q1.push_back({!r && m_known, e});
      if (r) begin
        m_ex[d] = '0; m_mem[d] = '0; m_wb[d] = '0; m_owe[d] = 0;
      end else if (adv) begin
        m_wb[d]  = m_mem[d];
        m_mem[d] = m_ex[d];
        m_ex[d]  = bub ? '0 : ns;
      end
    end
    if (r) m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------------------
  task automatic chk(input int d, input logic [8:0] got);
    logic [9:0] e;
    bit         empty;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      vectors++;
      miscompares++;
      $display("FAIL queue_empty LOAD_LAT=%0d t=%0t got %b required an expectation",
               lat_of(d), $time, got);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e[9]) begin
      vectors++;
      if (got !== e[8:0]) begin
        miscompares++;
        $display("FAIL outputs LOAD_LAT=%0d t=%0t got %b required %b (fa fb pc ifs iff idf frz)",
                 lat_of(d), $time, got, e[8:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      chk(0, got1);
      chk(1, got3);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ex[d] = '0; m_mem[d] = '0; m_wb[d] = '0; m_owe[d] = 0;
    end
    @(posedge clk);
    #1;
    running = 1'b1;

    // Reset, then quiet cycles: all outputs low, selects 00.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // r3 produced twice back to back, consumer reads r3 on rs: MEM beats WB.
    cyc(1, 1, 2, 3, 1, 1, 0, 0, 0, 0);
    cyc(1, 4, 5, 3, 1, 1, 0, 0, 0, 0);
    cyc(1, 3, 3, 7, 1, 1, 0, 0, 0, 0);
    idle(3);

    // Writes to r0 are never forwarded.
    cyc(1, 1, 2, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 8, 1, 1, 0, 0, 0, 0);
    idle(3);

    // lw r5 then consumer reading r5 through rt (held in ID while stalled).
    cyc(1, 1, 0, 5, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2, 5, 6, 1, 1, 0, 0, 0, 0);
    idle(4);

    // Load-use with mem_wait pulsed for two cycles in the middle of the stall.
    cyc(1, 1, 0, 5, 0, 1, 1, 0, 0, 0);
    cyc(1, 5, 2, 6, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 2, 6, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 2, 6, 0, 1, 0, 0, 1, 0);
    cyc(1, 5, 2, 6, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc(1, 5, 2, 6, 0, 1, 0, 0, 0, 0);
    idle(4);

    // Taken branch in the same cycle as a load-use hazard: flush only.
    cyc(1, 1, 0, 5, 0, 1, 1, 0, 0, 0);
    cyc(1, 5, 0, 6, 0, 1, 0, 1, 0, 0);
    idle(3);

    // Reset in the middle of a LOAD_LAT=3 stall.
    cyc(1, 1, 0, 5, 0, 1, 1, 0, 0, 0);
    cyc(1, 5, 0, 6, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 6, 0, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 6, 0, 1, 0, 0, 0, 1);
`ifdef HZD_STATS_EN
    vectors++;
    if ({slu1, sfl1, sfz1, slu3, sfl3, sfz3} !== '0) begin
      miscompares++;
      $display("FAIL stats_after_reset got %0d %0d %0d %0d %0d %0d required all 0",
               slu1, sfl1, sfz1, slu3, sfl3, sfz3);
    end
`endif
    idle(2);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) != 0, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
          ($urandom % 2) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
          ($urandom % 10) == 0, ($urandom % 8) == 0, ($urandom % 97) == 0);
    end
    idle(2);

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
